asmd_mult_sequencer: RTL and testbench

Upstream front-end for asmd_multiplier.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Drives the multiplier's start/word0/word1 one job at a time, waits for its ready, then captures the product.
- Presents each product on a valid/ready output stream, with job order preserved.
- Detects a hung multiplier with a cycle timeout.

---
 rtl/asmd_pkg.sv | 23 ++
 rtl/asmd_operand_fifo.sv | 86 ++++++++
 rtl/asmd_mult_sequencer.sv | 147 ++++++++++++++
 tb/tb_asmd_mult_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/asmd_pkg.sv
// ---------------------------------------------------------------------------
// asmd_pkg
// Shared definitions for the ASMD multiplier front-end:
//   - ASMD_WORD_LENGTH : default operand width
//   - seq_state_e      : sequencer FSM states
//   - product_width()  : product width for a given operand width
// ---------------------------------------------------------------------------
package asmd_pkg;

    localparam int unsigned ASMD_WORD_LENGTH = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        OUTPUT    = 2'd3
    } seq_state_e;

    function automatic int unsigned product_width(input int unsigned word_length);
        return 2 * word_length;
    endfunction

endpackage

// File: rtl/asmd_operand_fifo.sv
// ---------------------------------------------------------------------------
// asmd_operand_fifo
// Synchronous FIFO holding operand pairs for the sequencer.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_i         : write wr_data_i (ignored while full)
//   wr_data_i      : entry to write
//   pop_i          : drop the head entry (ignored while empty)
//   rd_data_o      : head entry (valid while !empty_o)
//   count_o        : number of entries held
//   empty_o        : no entries held
//   not_full_o     : registered "can accept"; low during reset
// ---------------------------------------------------------------------------
module asmd_operand_fifo
    import asmd_pkg::*;
#(
    parameter int unsigned DATA_W = product_width(ASMD_WORD_LENGTH),
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      not_full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              not_full_q, not_full_d;
    logic              do_push, do_pop;

    assign do_push = push_i && not_full_q;
    assign do_pop  = pop_i && (count_q != '0);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Computed from the next count so the registered flag never lags.
        not_full_d = (count_d != CNT_W'(DEPTH));
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign not_full_o = not_full_q;

endmodule

// File: rtl/asmd_mult_sequencer.sv
// ---------------------------------------------------------------------------
// asmd_mult_sequencer
// Front-end for asmd_multiplier: queues operand pairs, runs one multiply at
// a time, and returns products in acceptance order. A job whose multiplier
// does not answer within TIMEOUT cycles is dropped and flagged.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_word0/1     : operand-pair input stream
//   out_valid/out_ready/out_product  : product output stream
//   mul_start/mul_word0/1            : drive to the multiplier
//   mul_product/mul_ready            : response from the multiplier
//   busy                             : job in progress or queued
//   timeout_err                      : sticky abort flag, cleared by reset
//   fifo_count                       : queued operand pairs
// ---------------------------------------------------------------------------
module asmd_mult_sequencer
    import asmd_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = ASMD_WORD_LENGTH,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_LENGTH-1:0]      in_word0,
    input  logic [WORD_LENGTH-1:0]      in_word1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_LENGTH-1:0]    out_product,
    output logic                        mul_start,
    output logic [WORD_LENGTH-1:0]      mul_word0,
    output logic [WORD_LENGTH-1:0]      mul_word1,
    input  logic [2*WORD_LENGTH-1:0]    mul_product,
    input  logic                        mul_ready,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PROD_W   = product_width(WORD_LENGTH);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    seq_state_e               state_q;
    logic [TMO_W-1:0]         tmo_q;
    logic                     mul_start_q;
    logic [WORD_LENGTH-1:0]   op0_q, op1_q;
    logic                     out_valid_q;
    logic [PROD_W-1:0]        out_product_q;
    logic                     timeout_err_q;

    logic                     fifo_push, fifo_pop, fifo_empty, fifo_not_full;
    logic [PROD_W-1:0]        fifo_wr_data, fifo_rd_data;

    // Entry layout: word1 in the upper half, word0 in the lower half.
    assign fifo_wr_data = {in_word1, in_word0};
    assign fifo_push    = in_valid && fifo_not_full;
    assign fifo_pop     = (state_q == IDLE) && !fifo_empty;

    asmd_operand_fifo #(
        .DATA_W (PROD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .wr_data_i  (fifo_wr_data),
        .pop_i      (fifo_pop),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .not_full_o (fifo_not_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tmo_q         <= '0;
            mul_start_q   <= 1'b0;
            op0_q         <= '0;
            op1_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        op0_q       <= fifo_rd_data[WORD_LENGTH-1:0];
                        op1_q       <= fifo_rd_data[PROD_W-1:WORD_LENGTH];
                        mul_start_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                // Start is held until the multiplier acknowledges by
                // dropping ready; a freshly reset multiplier already has
                // ready low, so this may last a single cycle.
                ISSUE: begin
                    if (!mul_ready) begin
                        mul_start_q <= 1'b0;
                        tmo_q       <= tmo_q + TMO_W'(1);
                        state_q     <= WAIT_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        mul_start_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (mul_ready) begin
                        out_product_q <= mul_product;
                        out_valid_q   <= 1'b1;
                        state_q       <= OUTPUT;
                    end else if (tmo_q == TMO_LAST) begin
                        // Hung multiplier: the job is dropped without output.
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = fifo_not_full;
    assign mul_start   = mul_start_q;
    assign mul_word0   = op0_q;
    assign mul_word1   = op1_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_asmd_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_asmd_mult_sequencer
// Directed bench for asmd_mult_sequencer with a behavioural multiplier model
// (configurable latency, optional stuck mode) and a product scoreboard.
// ---------------------------------------------------------------------------
module tb_asmd_mult_sequencer;

    localparam int WL    = 4;
    localparam int PW    = 2 * WL;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready;
    logic [WL-1:0] in_word0, in_word1;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_product;
    logic          mul_start;
    logic [WL-1:0] mul_word0, mul_word1;
    logic [PW-1:0] mul_product;
    logic          mul_ready;
    logic          busy, timeout_err;
    logic [2:0]    fifo_count;

    int checks    = 0;
    int failures  = 0;
    int out_count = 0;
    logic [PW-1:0] sb_q[$];
    logic [PW-1:0] exp_p;

    always #5 clk = ~clk;

    asmd_mult_sequencer #(
        .WORD_LENGTH (WL),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word0    (in_word0),
        .in_word1    (in_word1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .mul_start   (mul_start),
        .mul_word0   (mul_word0),
        .mul_word1   (mul_word1),
        .mul_product (mul_product),
        .mul_ready   (mul_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count)
    );

    // Multiplier model: ready low after reset, samples start when idle,
    // raises ready with the product mdl_lat+1 cycles later.
    logic          mdl_stuck;
    int            mdl_lat;
    logic          mdl_busy;
    int            mdl_cnt;
    logic [WL-1:0] mdl_a, mdl_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_ready   <= 1'b0;
            mul_product <= '0;
            mdl_busy    <= 1'b0;
            mdl_cnt     <= 0;
            mdl_a       <= '0;
            mdl_b       <= '0;
        end else if (mdl_stuck) begin
            mul_ready <= 1'b0;
        end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                mul_ready   <= 1'b1;
                mul_product <= {4'b0, mdl_a} * {4'b0, mdl_b};
                mdl_busy    <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            mdl_busy  <= 1'b1;
            mdl_cnt   <= mdl_lat;
            mdl_a     <= mul_word0;
            mdl_b     <= mul_word1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: push on accepted pairs, pop and compare on
    // product handshakes, and check operands stay put while the model works.
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready)
                sb_q.push_back({4'b0, in_word0} * {4'b0, in_word1});
            if (out_valid && out_ready) begin
                out_count++;
                check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_p = sb_q.pop_front();
                    check("out_product", 32'(out_product), 32'(exp_p));
                end
            end
            if (mdl_busy) begin
                check("word0_stable", 32'(mul_word0), 32'(mdl_a));
                check("word1_stable", 32'(mul_word1), 32'(mdl_b));
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WL-1:0] a, input logic [WL-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_word0 = a;
        in_word1 = b;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_bound", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int target);
        int n = 0;
        while (out_count < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_count", 32'(out_count), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_word0  = '0;
        in_word1  = '0;
        out_ready = 1'b0;
        mdl_stuck = 1'b0;
        mdl_lat   = 3;

        // Reset values
        idle(3);
        check("rst_in_ready",    32'(in_ready),    32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_product", 32'(out_product), 32'd0);
        check("rst_mul_start",   32'(mul_start),   32'd0);
        check("rst_mul_word0",   32'(mul_word0),   32'd0);
        check("rst_mul_word1",   32'(mul_word1),   32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_fifo_count",  32'(fifo_count),  32'd0);
        reset_n = 1'b1;
        idle(1);
        check("post_rst_in_ready",   32'(in_ready),   32'd1);
        check("post_rst_fifo_count", 32'(fifo_count), 32'd0);
        check("post_rst_busy",       32'(busy),       32'd0);

        // Single job 5*3 with start latency
        out_ready = 1'b1;
        send(4'd5, 4'd3);
        check("one_fifo_count", 32'(fifo_count), 32'd1);
        check("start_before",   32'(mul_start),  32'd0);
        idle(1);
        check("start_latency",  32'(mul_start),  32'd1);
        check("issue_word0",    32'(mul_word0),  32'd5);
        check("issue_word1",    32'(mul_word1),  32'd3);
        check("issue_busy",     32'(busy),       32'd1);
        wait_outputs(1);
        idle(10);
        check("single_output_only", 32'(out_count), 32'd1);
        check("single_idle_busy",   32'(busy),      32'd0);

        // Extreme operands
        send(4'hF, 4'hF);
        send(4'h0, 4'hA);
        wait_outputs(3);

        // Backpressure: six back-to-back pairs with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(4'(i), 4'(i));
        in_valid = 1'b1;
        in_word0 = 4'd6;
        in_word1 = 4'd6;
        idle(20);
        check("bp_in_ready",    32'(in_ready),    32'd0);
        check("bp_fifo_count",  32'(fifo_count),  32'd4);
        check("bp_out_valid",   32'(out_valid),   32'd1);
        check("bp_held_prod",   32'(out_product), 32'd1);
        check("bp_no_handshake", 32'(out_count),  32'd3);
        out_ready = 1'b1;
        send(4'd6, 4'd6);
        wait_outputs(9);
        check("bp_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a job with two pairs queued
        mdl_lat = 20;
        send(4'd1, 4'd2);
        send(4'd2, 4'd3);
        send(4'd3, 4'd4);
        idle(2);
        check("mid_fifo_count", 32'(fifo_count), 32'd2);
        check("mid_busy",       32'(busy),       32'd1);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_mul_start",  32'(mul_start),  32'd0);
        check("mid_rst_out_valid",  32'(out_valid),  32'd0);
        check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy",       32'(busy),       32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        mdl_lat = 3;
        send(4'd7, 4'd2);
        wait_outputs(10);

        // Hung multiplier: abort after TIMEOUT cycles, then recover
        mdl_stuck = 1'b1;
        idle(2);
        send(4'd4, 4'd4);
        n = 0;
        while (!mul_start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_start_seen", 32'(mul_start), 32'd1);
        n = 0;
        while (!timeout_err && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles",    32'(n),           32'(TMO));
        check("tmo_err_set",   32'(timeout_err), 32'd1);
        check("tmo_out_valid", 32'(out_valid),   32'd0);
        check("tmo_mul_start", 32'(mul_start),   32'd0);
        check("tmo_idle",      32'(busy),        32'd0);
        check("tmo_dropped",   32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        mdl_stuck = 1'b0;
        idle(3);
        check("tmo_no_output", 32'(out_count), 32'd10);
        send(4'd3, 4'd3);
        wait_outputs(11);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
